decode_ctrl: RTL
================

# decode_ctrl

Registered, handshaked instruction decoder with a condition-code register and writeback-hazard tracking. It accepts 16-bit instructions from fetch, holds decoded control (ALU op, source select, register write, memory read/write, resolved branch) in an output register for the execute stage, and keeps the NZP flags from register-file writebacks. Conditional branches stall until every older register-writing instruction has written back, so branch resolution always sees current flags.

## Interface
One clock; reset is synchronous and active-high.

Parameters:
- DATA_W, 16: datapath width for `wb_data` and `imm`; must be 16 or more.
- MAX_PEND, 4: maximum outstanding register writes, from 2 to 15.
- ENABLE_MEM, 1: when 1, LD and LST are legal; when 0, they decode as illegal.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instr_valid  in  1  fetch presents an instruction
- instr  in  16  instruction word
- instr_ready  out  1  decoder accepts this cycle
- wb_valid  in  1  register-file write occurs this cycle
- wb_data  in  DATA_W  value being written back
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes the bundle
- alu_op  out  2  instr[15:14]
- ssel  out  2  00 = sign-extended immediate, 01 = PC, 10 = sr2
- we_reg, mem_rd, mem_wr, branch_taken, illegal  out  1 each  control bits
- dr, sr1, sr2  out  3 each  instr[11:9], instr[8:6], instr[2:0]
- imm  out  DATA_W  sign-extended immediate
- nzp  out  3  current condition codes
- stalled  out  1  high while in WAIT_CC

## Operation
Opcodes:
- BR = 0000
- ADD = 0001
- LD = 0010
- ST = 0011
- AND = 0101
- NOT = 1001
- JMP = 1100
- LEA = 1110
- Any other opcode: `illegal` = 1 and all enables are 0.

Decoded fields:
- `we_reg`: ADD, AND, NOT, LEA, LD.
- `mem_rd`: LD.
- `mem_wr`: ST.
- `ssel`:
  - 00 when instr[5] = 1 and instr[13:12] = 01.
  - 01 for LEA, LD, ST.
  - 10 otherwise.
- `imm`:
  - instr[4:0] sign-extended for ADD and AND.
  - instr[8:0] sign-extended for all other opcodes.
- `branch_taken`:
  - JMP: 1.
  - BR: |(instr[11:9] & nzp) evaluated at resolution time. Field 000 gives 0.
  - All other opcodes: 0.

Condition codes:
- On `wb_valid`, nzp <= {msb, all-zero, neither} of `wb_data`.
- Reset value is 010.

Pending counter `pend` (0..MAX_PEND):
- +1 when a `we_reg` instruction is accepted.
- −1 on `wb_valid`.
- Both in the same cycle: unchanged.
- `wb_valid` with pend = 0: pend stays 0, nzp still updates.

States:
- RUN:
  - instr_ready = (!out_valid | out_ready) & (pend < MAX_PEND).
  - Accepting a non-BR instruction, or a BR with pend = 0: the output register loads and out_valid <= 1.
  - Accepting a BR with pend ≠ 0: the instruction goes into the hold register, out_valid <= 0, and the next state is WAIT_CC.
  - No accept while out_ready: out_valid <= 0.
- WAIT_CC:
  - instr_ready = 0 and stalled = 1.
  - When registered pend = 0, the held BR resolves against the registered nzp, loads the output register with out_valid <= 1, and returns to RUN.
- Output hold: while out_valid & !out_ready, every output field stays stable.

Reset:
- state RUN, pend 0, nzp 010.
- out_valid and every decoded output 0.
- A branch held in WAIT_CC is discarded.

## Timing
- Non-stalled instruction: accepted at edge k, out_valid from cycle k+1.
- Back-to-back throughput is one per cycle while out_ready = 1.
- Stalled BR: the last `wb_valid` is sampled at edge j, so pend and nzp update at j. The branch resolves in cycle j+1 and out_valid is high from j+2.
- BR accepted in the same cycle as a `wb_valid` that drops pend to 0: the check uses the pre-edge pend, so the BR still enters WAIT_CC for at least one cycle.
- `instr_ready` is combinational from state, pend, out_valid and out_ready only. It never depends on `instr_valid`.

## Test plan
- **Reset check:** assert rst for 2 cycles mid-stream → out_valid = 0, nzp = 010, stalled = 0, and instr_ready = 1 on the first cycle after release.
- **Immediate ADD:** ADD 0x1265 (R1 = R1 + imm 5) → next cycle we_reg = 1, ssel = 00, imm = 0x0005, dr = 1, alu_op = 00. Then BR n (0x0800) with pend = 1 → stalled until `wb_valid` with wb_data = 0xFFFF; branch_taken = 1 two cycles after that writeback.
- **Pending limit:** MAX_PEND = 4, issue 4 ADDs with no writeback → instr_ready = 0. One `wb_valid` → instr_ready = 1 the following cycle.
- **Backpressure:** out_ready = 0 for 3 cycles with a LEA (0xE3FF) valid → outputs stay at ssel = 01, imm = 0xFFFF, and instr_ready stays 0.
- **Illegal opcodes:** opcode 1101 → illegal = 1 with all enables 0. With ENABLE_MEM = 0, LD 0x2000 → illegal = 1.
- **Writeback edge cases:** simultaneous accept of ADD and `wb_valid` → pend unchanged. `wb_valid` with pend = 0 → pend stays 0, and nzp becomes 001 for wb_data = 0x0003.

Source files
------------

// File: rtl/decode_ctrl.sv
// Registered, handshaked instruction decoder with NZP condition codes and
// writeback tracking so conditional branches resolve only against current flags.
module decode_ctrl #(
  parameter int DATA_W     = 16,
  parameter int MAX_PEND   = 4,
  parameter int ENABLE_MEM = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic [15:0]       instr,
  output logic              instr_ready,
  input  logic              wb_valid,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        alu_op,
  output logic [1:0]        ssel,
  output logic              we_reg,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic              branch_taken,
  output logic              illegal,
  output logic [2:0]        dr,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [DATA_W-1:0] imm,
  output logic [2:0]        nzp,
  output logic              stalled
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;
  localparam logic [3:0] PEND_MAX = 4'(MAX_PEND);

  logic [0:0]        state;
  logic [3:0]        pend;
  logic [15:0]       hold;
  logic [15:0]       dword;
  logic [3:0]        opc;
  logic              d_we, d_mrd, d_mwr, d_br, d_ill;
  logic [1:0]        d_ssel;
  logic [DATA_W-1:0] d_imm;
  logic              accept, is_br, inc, dec;

  assign instr_ready = (state == S_RUN) && (!out_valid || out_ready) && (pend < PEND_MAX);
  assign accept      = instr_valid && instr_ready;
  assign is_br       = (instr[15:12] == 4'b0000);
  assign stalled     = (state == S_WAIT);
  // While stalled the held branch is the word being decoded.
  assign dword       = (state == S_WAIT) ? hold : instr;
  assign opc         = dword[15:12];
  assign inc         = accept && d_we;
  assign dec         = wb_valid && (pend != 4'd0);

  always_comb begin
    d_we   = 1'b0;
    d_mrd  = 1'b0;
    d_mwr  = 1'b0;
    d_br   = 1'b0;
    d_ill  = 1'b0;
    case (opc)
      4'b0000: d_br = |(dword[11:9] & nzp);
      4'b0001, 4'b0101, 4'b1001, 4'b1110: d_we = 1'b1;
      4'b0010: begin
        if (ENABLE_MEM != 0) begin
          d_we  = 1'b1;
          d_mrd = 1'b1;
        end else begin
          d_ill = 1'b1;
        end
      end
      4'b0011: begin
        if (ENABLE_MEM != 0) d_mwr = 1'b1;
        else d_ill = 1'b1;
      end
      4'b1100: d_br = 1'b1;
      default: d_ill = 1'b1;
    endcase
    if (dword[5] && (dword[13:12] == 2'b01)) d_ssel = 2'b00;
    else if ((opc == 4'b1110) || (opc == 4'b0010) || (opc == 4'b0011)) d_ssel = 2'b01;
    else d_ssel = 2'b10;
    if ((opc == 4'b0001) || (opc == 4'b0101)) d_imm = {{(DATA_W-5){dword[4]}}, dword[4:0]};
    else d_imm = {{(DATA_W-9){dword[8]}}, dword[8:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RUN;
      pend         <= 4'd0;
      nzp          <= 3'b010;
      hold         <= 16'd0;
      out_valid    <= 1'b0;
      alu_op       <= 2'b00;
      ssel         <= 2'b00;
      we_reg       <= 1'b0;
      mem_rd       <= 1'b0;
      mem_wr       <= 1'b0;
      branch_taken <= 1'b0;
      illegal      <= 1'b0;
      dr           <= 3'd0;
      sr1          <= 3'd0;
      sr2          <= 3'd0;
      imm          <= '0;
    end else begin
      case ({inc, dec})
        2'b10:   pend <= pend + 4'd1;
        2'b01:   pend <= pend - 4'd1;
        default: pend <= pend;
      endcase
      if (wb_valid) begin
        nzp <= {wb_data[DATA_W-1], (wb_data == '0), (!wb_data[DATA_W-1] && (wb_data != '0))};
      end
      // A decoded bundle is loaded on a direct accept or on stalled-branch resolution.
      if ((state == S_RUN && accept && !(is_br && pend != 4'd0)) ||
          (state == S_WAIT && pend == 4'd0)) begin
        out_valid    <= 1'b1;
        alu_op       <= dword[15:14];
        ssel         <= d_ssel;
        we_reg       <= d_we;
        mem_rd       <= d_mrd;
        mem_wr       <= d_mwr;
        branch_taken <= d_br;
        illegal      <= d_ill;
        dr           <= dword[11:9];
        sr1          <= dword[8:6];
        sr2          <= dword[2:0];
        imm          <= d_imm;
        state        <= S_RUN;
      end else if (state == S_RUN && accept) begin
        hold      <= instr;
        out_valid <= 1'b0;
        state     <= S_WAIT;
      end else if (state == S_RUN && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule
